fetch_fifo: RTL and testbench

Instruction queue between the fetch stage and the decode/issue stage. Buffers up to DEPTH fetched instruction words with their PC, `branchpredict_sbe` hint and `exception` record, all typed from `ariane_pkg`. It decouples fetch stalls from issue stalls with a valid/ready handshake on each side. It supports a single-cycle flush on mispredict or exception, and stops accepting new entries after it has accepted an entry that carries an exception.

---
 rtl/ariane_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 136 +++++++++++++
 tb/tb_fetch_fifo.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ariane_pkg.sv
// Shared fetch/issue types: exception record and branch-prediction hint
// carried alongside each fetched instruction.
package ariane_pkg;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] predict_address;
    logic        predict_taken;
    logic        is_lower_16;
  } branchpredict_sbe_t;

  localparam logic [63:0] INSTR_ACCESS_FAULT = 64'h1;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction queue between fetch and decode/issue: circular buffer of
// {pc, instr, bp, ex} with flush and a lock that stops intake after a fault.
module fetch_fifo
  import ariane_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [63:0]              in_pc_i,
  input  logic [31:0]              in_instr_i,
  input  branchpredict_sbe_t       in_bp_i,
  input  exception_t               in_ex_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [63:0]              out_pc_o,
  output logic [31:0]              out_instr_o,
  output branchpredict_sbe_t       out_bp_o,
  output exception_t               out_ex_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [63:0]        pc;
    logic [31:0]        instr;
    branchpredict_sbe_t bp;
    exception_t         ex;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ex_lock_q, ex_lock_d;

  entry_t             in_entry;
  entry_t             head;
  logic               push;
  logic               pop;

  // Neither handshake may complete while flushing or resetting.
  assign in_ready_o  = (count_q != CNT_W'(DEPTH)) & ~ex_lock_q & ~flush_i & ~rst_i;
  assign out_valid_o = (count_q != '0) & ~flush_i & ~rst_i;
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;
  assign count_o     = count_q;

  always_comb begin
    in_entry       = '0;
    in_entry.pc    = in_pc_i;
    in_entry.instr = in_instr_i;
    in_entry.bp    = in_bp_i;
    in_entry.ex    = in_ex_i;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (push) begin
      mem_d[wr_ptr_q] = in_entry;
    end
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ex_lock_d = ex_lock_q;
    if (flush_i) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      ex_lock_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
      if (push && in_ex_i.valid) begin
        ex_lock_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ex_lock_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ex_lock_q <= ex_lock_d;
    end
  end

  // Storage is deliberately left out of reset/flush; validity comes from count.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  assign head = mem_q[rd_ptr_q];

  always_comb begin
    out_pc_o    = '0;
    out_instr_o = '0;
    out_bp_o    = '0;
    out_ex_o    = '0;
    if (out_valid_o) begin
      out_pc_o    = head.pc;
      out_instr_o = head.instr;
      out_bp_o    = head.bp;
      out_ex_o    = head.ex;
    end
  end

endmodule

// File: tb/tb_fetch_fifo.sv
// Bench for fetch_fifo: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fetch_fifo;
  import ariane_pkg::*;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [63:0]        pc;
    logic [31:0]        instr;
    branchpredict_sbe_t bp;
    exception_t         ex;
  } ent_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               flush = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [63:0]        in_pc = '0;
  logic [31:0]        in_instr = '0;
  branchpredict_sbe_t in_bp = '0;
  exception_t         in_ex = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [63:0]        out_pc;
  logic [31:0]        out_instr;
  branchpredict_sbe_t out_bp;
  exception_t         out_ex;
  logic [2:0]         count;

  int total = 0;
  int bad   = 0;

  fetch_fifo #(.DEPTH(DEPTH)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_pc_i     (in_pc),
    .in_instr_i  (in_instr),
    .in_bp_i     (in_bp),
    .in_ex_i     (in_ex),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_pc_o    (out_pc),
    .out_instr_o (out_instr),
    .out_bp_o    (out_bp),
    .out_ex_o    (out_ex),
    .count_o     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain queue plus lock flag, advanced at each negedge
  // using the inputs that will be sampled on the following rising edge.
  ent_t model_q[$];
  bit   model_lock = 1'b0;
  bit   model_live = 1'b0;

  always @(negedge clk) begin
    ent_t exp_head;
    ent_t in_e;
    bit   exp_ready, exp_valid, exp_push, exp_pop;
    exp_ready = (model_q.size() != DEPTH) && !model_lock && !flush && !rst;
    exp_valid = (model_q.size() != 0) && !flush && !rst;
    exp_head  = exp_valid ? model_q[0] : '0;
    if (model_live) begin
      chk("cyc_in_ready",  256'(in_ready),  256'(exp_ready));
      chk("cyc_out_valid", 256'(out_valid), 256'(exp_valid));
      chk("cyc_count",     256'(count),     256'(model_q.size()));
      chk("cyc_out_pc",    256'(out_pc),    256'(exp_head.pc));
      chk("cyc_out_instr", 256'(out_instr), 256'(exp_head.instr));
      chk("cyc_out_bp",    256'(out_bp),    256'(exp_head.bp));
      chk("cyc_out_ex",    256'(out_ex),    256'(exp_head.ex));
    end
    if (rst) begin
      model_q.delete();
      model_lock = 1'b0;
      model_live = 1'b1;
    end else if (model_live) begin
      if (flush) begin
        model_q.delete();
        model_lock = 1'b0;
      end else begin
        exp_push = in_valid && exp_ready;
        exp_pop  = exp_valid && out_ready;
        if (exp_pop) void'(model_q.pop_front());
        if (exp_push) begin
          in_e.pc    = in_pc;
          in_e.instr = in_instr;
          in_e.bp    = in_bp;
          in_e.ex    = in_ex;
          model_q.push_back(in_e);
          if (in_ex.valid) model_lock = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("reset_ready", 256'(in_ready),  256'(1));
    chk("reset_valid", 256'(out_valid), 256'(0));
    chk("reset_count", 256'(count),     256'(0));
    chk("reset_pc",    256'(out_pc),    256'(0));

    // Fill with decode stalled
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_pc    = 64'h1000 + 64'(4 * k);
      in_instr = 32'h13 + 32'(k);
      tick();
      chk("fill_count", 256'(count), 256'(k + 1));
      chk("fill_head_pc", 256'(out_pc), 256'(64'h1000));
    end
    chk("full_ready", 256'(in_ready), 256'(0));

    // Full with decode ready: pop happens, push does not
    out_ready = 1'b1;
    #1;
    chk("full_ready_with_out_ready", 256'(in_ready), 256'(0));
    tick();
    chk("full_pop_count", 256'(count),    256'(3));
    chk("full_pop_ready", 256'(in_ready), 256'(1));
    chk("full_pop_head",  256'(out_pc),   256'(64'h1004));
    in_valid = 1'b0;
    repeat (3) tick();
    chk("drained_count", 256'(count), 256'(0));

    // Streaming through, pointers wrap twice
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      in_pc    = 64'h2000 + 64'(4 * k);
      tick();
      chk("stream_head_pc", 256'(out_pc), 256'(64'h2000 + 64'(4 * k)));
      chk("stream_count",   256'(count),  256'(1));
    end
    in_valid = 1'b0;
    tick();
    chk("stream_end_count", 256'(count), 256'(0));

    // Exception lock
    out_ready      = 1'b0;
    in_valid       = 1'b1;
    in_pc          = 64'h3000;
    in_ex          = '0;
    in_ex.valid    = 1'b1;
    in_ex.cause    = INSTR_ACCESS_FAULT;
    tick();
    in_ex = '0;
    in_pc = 64'h3004;
    chk("exlock_ready",    256'(in_ready),     256'(0));
    chk("exlock_cause",    256'(out_ex.cause), 256'(1));
    chk("exlock_ex_valid", 256'(out_ex.valid), 256'(1));
    chk("exlock_pc",       256'(out_pc),       256'(64'h3000));
    out_ready = 1'b1;
    tick();
    chk("exlock_drained_valid", 256'(out_valid), 256'(0));
    chk("exlock_drained_ready", 256'(in_ready),  256'(0));
    tick();
    chk("exlock_hold_ready", 256'(in_ready), 256'(0));
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("exlock_after_flush_ready", 256'(in_ready), 256'(1));

    // Flush mid-operation
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_pc    = 64'h3100 + 64'(4 * k);
      tick();
    end
    chk("preflush_count", 256'(count), 256'(3));
    flush     = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("flush_cycle_ready", 256'(in_ready),  256'(0));
    chk("flush_cycle_valid", 256'(out_valid), 256'(0));
    tick();
    flush     = 1'b0;
    out_ready = 1'b0;
    in_pc     = 64'h4000;
    #1;
    chk("postflush_count", 256'(count),    256'(0));
    chk("postflush_ready", 256'(in_ready), 256'(1));
    tick();
    in_valid = 1'b0;
    chk("postflush_head", 256'(out_pc), 256'(64'h4000));
    chk("postflush_cnt1", 256'(count),  256'(1));

    // Reset with entries queued and the lock set
    in_valid    = 1'b1;
    in_pc       = 64'h5000;
    in_ex.valid = 1'b1;
    in_ex.cause = INSTR_ACCESS_FAULT;
    tick();
    in_valid = 1'b0;
    in_ex    = '0;
    #1;
    chk("prerst_count", 256'(count),    256'(2));
    chk("prerst_ready", 256'(in_ready), 256'(0));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_count", 256'(count),     256'(0));
    chk("midrst_ready", 256'(in_ready),  256'(1));
    chk("midrst_valid", 256'(out_valid), 256'(0));
    chk("midrst_pc",    256'(out_pc),    256'(0));
    chk("midrst_instr", 256'(out_instr), 256'(0));
    chk("midrst_bp",    256'(out_bp),    256'(0));
    chk("midrst_ex",    256'(out_ex),    256'(0));

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      rst       = ($urandom_range(0, 127) == 0);
      in_pc     = {$urandom, $urandom};
      in_instr  = $urandom;
      in_bp.valid           = 1'($urandom_range(0, 1));
      in_bp.predict_address = {$urandom, $urandom};
      in_bp.predict_taken   = 1'($urandom_range(0, 1));
      in_bp.is_lower_16     = 1'($urandom_range(0, 1));
      in_ex.valid = ($urandom_range(0, 15) == 0);
      in_ex.cause = 64'($urandom_range(0, 15));
      in_ex.tval  = {$urandom, $urandom};
      tick();
    end
    rst = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
